// File: rtl/dmio_arbiter.sv
// Two-requester arbiter for a single-port DMIO bus; DMIO_ARB_ROUND_ROBIN_EN selects round-robin ties (default: req0 fixed priority).
// Latency: request sampled in IDLE -> DMIO access next cycle -> ack the cycle after; one access every 3 cycles at most.
// Backpressure: requesters hold req until their ack; a losing requester simply waits, nothing is queued or dropped.
module dmio_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] direccion,
    output logic [DATA_W-1:0] dataWrite,
    output logic              memWr,
    input  logic [DATA_W-1:0] dataRead,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic grantNow;   // an access is granted on this edge
    logic pick;       // 0 selects requester 0, 1 selects requester 1
    logic winner;     // requester owning the transaction in flight
    logic latWe;

    assign grantNow = (state == IDLE) && (req0 || req1);

`ifdef DMIO_ARB_ROUND_ROBIN_EN
    logic lastGrant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = ~req0;
        if (req0 && req1) begin
            pick = ~lastGrant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= 1'b1;
        end else if (grantNow) begin
            lastGrant <= pick;
        end
    end
`else
    // req0 wins whenever it is present.
    assign pick = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b1;
        memWr     = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                memWr     = latWe;
                nextState = DONE;
            end
            DONE: begin
                ack0      = ~winner;
                ack1      = winner;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // direccion/dataWrite double as the latched request, so they naturally
    // hold their last driven value once the access cycle is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner    <= 1'b0;
            latWe     <= 1'b0;
            direccion <= '0;
            dataWrite <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (grantNow) begin
                winner    <= pick;
                latWe     <= pick ? we1 : we0;
                direccion <= pick ? addr1 : addr0;
                dataWrite <= pick ? wdata1 : wdata0;
            end
            if ((state == ACCESS) && !latWe) begin
                if (winner) begin
                    rdata1 <= dataRead;
                end else begin
                    rdata0 <= dataRead;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmio_arbiter.sv
// Bench for dmio_arbiter: directed scenarios plus random traffic checked against a transaction-age model.
module tb_dmio_arbiter;
    localparam int AW = 13;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] direccion;
    logic [DW-1:0] dataWrite;
    logic          memWr;
    logic [DW-1:0] dataRead;
    logic          busy;

    always #5 clk = ~clk;

    dmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .direccion(direccion), .dataWrite(dataWrite), .memWr(memWr),
        .dataRead(dataRead), .busy(busy)
    );

    int nVec  = 0;
    int nFail = 0;

    // Model: age of the transaction in flight (0 none, 1 on the bus, 2 acking).
    int            mAge  = 0;
    bit            mWin  = 1'b0;
    bit            mWe   = 1'b0;
    bit            mLast = 1'b1;
    logic [AW-1:0] mDir  = '0;
    logic [DW-1:0] mDw   = '0;
    logic [DW-1:0] mRd0  = '0;
    logic [DW-1:0] mRd1  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        if (rst) begin
            mAge = 0; mDir = '0; mDw = '0; mRd0 = '0; mRd1 = '0; mLast = 1'b1;
        end else if (mAge == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) begin
`ifdef DMIO_ARB_ROUND_ROBIN_EN
                    mWin = !mLast;
`else
                    mWin = 1'b0;
`endif
                end else begin
                    mWin = req1;
                end
                mLast = mWin;
                mWe   = mWin ? we1 : we0;
                mDir  = mWin ? addr1 : addr0;
                mDw   = mWin ? wdata1 : wdata0;
                mAge  = 1;
            end
        end else if (mAge == 1) begin
            if (!mWe) begin
                if (mWin) mRd1 = dataRead;
                else      mRd0 = dataRead;
            end
            mAge = 2;
        end else begin
            mAge = 0;
        end
    endtask

    task automatic compareAll();
        check("busy",      64'(busy),      64'(mAge != 0));
        check("memWr",     64'(memWr),     64'((mAge == 1) && mWe));
        check("ack0",      64'(ack0),      64'((mAge == 2) && !mWin));
        check("ack1",      64'(ack1),      64'((mAge == 2) && mWin));
        check("rdata0",    rdata0,         mRd0);
        check("rdata1",    rdata1,         mRd1);
        check("direccion", 64'(direccion), 64'(mDir));
        check("dataWrite", dataWrite,      mDw);
    endtask

    // Inputs change only at negedge; the model sees exactly what the DUT samples.
    task automatic tick();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic randReq(input bit acked, input logic rIn, output logic rOut,
                           output bit chg);
        rOut = rIn;
        chg  = 1'b0;
        if (!rIn) begin
            if ($urandom_range(0, 2) == 0) begin rOut = 1'b1; chg = 1'b1; end
        end else if (acked) begin
            if ($urandom_range(0, 1) == 0) rOut = 1'b0;
            else chg = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
            rOut = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            chg = 1'b1;
        end
    endtask

    initial begin
        logic grants[$];
        logic expOrder[4];
        logic nr;
        bit   chg;

        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; dataRead = '0;
        tick();
        check("rst busy", 64'(busy), 64'd0);
        check("rst direccion", 64'(direccion), 64'd0);
        rst = 1'b0;
        tick();

        // Write from requester 0.
        req0 = 1; we0 = 1; addr0 = 13'h1AF2; wdata0 = 64'hF;
        tick();
        check("wr memWr", 64'(memWr), 64'd1);
        check("wr direccion", 64'(direccion), 64'h1AF2);
        check("wr dataWrite", dataWrite, 64'hF);
        check("wr early ack0", 64'(ack0), 64'd0);
        req0 = 0; addr0 = 13'h0555; wdata0 = 64'h77;
        tick();
        check("wr ack0", 64'(ack0), 64'd1);
        check("wr memWr done", 64'(memWr), 64'd0);
        check("wr rdata0", rdata0, 64'd0);
        tick();
        check("wr ack0 once", 64'(ack0), 64'd0);

        // Read from requester 1.
        req1 = 1; we1 = 0; addr1 = 13'h3;
        tick();
        check("rd memWr", 64'(memWr), 64'd0);
        check("rd direccion", 64'(direccion), 64'h3);
        req1 = 0; dataRead = 64'hCA;
        tick();
        check("rd ack1", 64'(ack1), 64'd1);
        check("rd ack0", 64'(ack0), 64'd0);
        check("rd rdata1", rdata1, 64'hCA);
        dataRead = 64'h55;
        tick();
        check("rd rdata1 hold", rdata1, 64'hCA);

        // Tie arbitration from a fresh reset.
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack0 || ack1) grants.push_back(ack1);
        end
        req0 = 0; req1 = 0;
        tick();
`ifdef DMIO_ARB_ROUND_ROBIN_EN
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        check("tie count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie grant%0d", i),
                  64'((i < grants.size()) ? grants[i] : 1'bx), 64'(expOrder[i]));
        end

        // Reset landing on the access cycle of a write.
        req0 = 1; we0 = 1; addr0 = 13'h4; wdata0 = 64'h1234;
        tick();
        check("rstacc memWr", 64'(memWr), 64'd1);
        rst = 1; req0 = 0;
        tick();
        check("rstacc busy", 64'(busy), 64'd0);
        check("rstacc memWr", 64'(memWr), 64'd0);
        rst = 0;
        tick();
        check("rstacc no ack", 64'(ack0), 64'd0);
        req1 = 1; we1 = 0; addr1 = 13'h7;
        tick();
        check("post rst direccion", 64'(direccion), 64'h7);
        req1 = 0; dataRead = 64'hBEEF;
        tick();
        check("post rst ack1", 64'(ack1), 64'd1);
        tick();

        // Requester withdraws during its access.
        req0 = 1; we0 = 0; addr0 = 13'h10;
        tick();
        req0 = 0;
        tick();
        check("drop ack0", 64'(ack0), 64'd1);
        tick();
        check("drop busy", 64'(busy), 64'd0);
        check("drop ack0 once", 64'(ack0), 64'd0);

        // Random traffic.
        for (int c = 0; c < 900; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            dataRead = {$urandom, $urandom};
            randReq((mAge == 2) && !mWin, req0, nr, chg);
            req0 = nr;
            if (chg) begin
                we0 = 1'($urandom); addr0 = 13'($urandom); wdata0 = {$urandom, $urandom};
            end
            randReq((mAge == 2) && mWin, req1, nr, chg);
            req1 = nr;
            if (chg) begin
                we1 = 1'($urandom); addr1 = 13'($urandom); wdata1 = {$urandom, $urandom};
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
